// File: rtl/fp_mul_pkg.sv
// Shared widths, FP32 constants and operand classes for the FP32 multiplier datapath.
package fp_mul_pkg;

  localparam int MANT_W = 24;
  localparam int PROD_W = 2 * MANT_W;
  localparam int EXP_W  = 10;

  localparam int          EXP_MAX = 255;
  localparam logic [7:0]  EXP_INF = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    CLS_NORM = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } class_t;

endpackage

// File: rtl/fp_mul_cpa_round_round_pack.sv
// Combinational normalize, round-to-nearest-even, exponent range check and FP32 packing.
module fp_round_pack
  import fp_mul_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 10
) (
  input  logic [2*MANT_W-1:0]      p,
  input  logic signed [EXP_W-1:0]  exp_val,
  input  logic                     sign,
  input  class_t                   cls,
  output logic [31:0]              result,
  output logic                     ovf,
  output logic                     unf,
  output logic                     inx
);

  localparam int PW = 2 * MANT_W;
  localparam int FW = MANT_W - 1;
  localparam logic signed [EXP_W:0] E_MAX  = (EXP_W + 1)'(EXP_MAX);
  localparam logic signed [EXP_W:0] E_ZERO = '0;
  localparam logic signed [EXP_W:0] E_ONE  = (EXP_W + 1)'(1);

  logic [FW-1:0]            frac;
  logic [FW:0]              frac_r;
  logic                     g;
  logic                     st;
  logic                     up;
  logic signed [EXP_W:0]    e;

  always_comb begin
    e = {exp_val[EXP_W-1], exp_val};
    if (p[PW-1]) begin
      frac = p[PW-2 -: FW];
      g    = p[PW-MANT_W-1];
      st   = |p[PW-MANT_W-2:0];
      e    = e + E_ONE;
    end else begin
      frac = p[PW-3 -: FW];
      g    = p[PW-MANT_W-2];
      st   = |p[PW-MANT_W-3:0];
    end

    up     = g & (st | frac[0]);
    frac_r = {1'b0, frac} + {{FW{1'b0}}, up};
    // A carry out of the fraction means 1.111..1 rounded to 2.0
    if (frac_r[FW]) e = e + E_ONE;

    result = '0;
    ovf    = 1'b0;
    unf    = 1'b0;
    inx    = 1'b0;
    case (cls)
      CLS_ZERO: result = {sign, 31'h0};
      CLS_INF:  result = {sign, EXP_INF, 23'h0};
      CLS_NAN:  result = QNAN;
      default: begin
        if (e >= E_MAX) begin
          result = {sign, EXP_INF, 23'h0};
          ovf    = 1'b1;
          inx    = 1'b1;
        end else if (e <= E_ZERO) begin
          result = {sign, 31'h0};
          unf    = 1'b1;
          inx    = 1'b1;
        end else begin
          result = {sign, e[7:0], frac_r[FW-1:0]};
          inx    = g | st;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_cpa_round.sv
// Two-stage split carry-propagate adder feeding FP32 round/pack, with valid/ready backpressure.
module fp_mul_cpa_round
  import fp_mul_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 10,
  parameter int HALF_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*MANT_W-1:0]      s_vec,
  input  logic [2*MANT_W-1:0]      c_vec,
  input  logic signed [EXP_W-1:0]  exp_in,
  input  logic                     sign_in,
  input  logic [1:0]               class_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              result,
  output logic                     flag_ovf,
  output logic                     flag_unf,
  output logic                     flag_inx
);

  localparam int PW   = 2 * MANT_W;
  localparam int HI_W = PW - HALF_W;

  logic                     va;
  logic                     vb;
  logic                     en_a;
  logic                     en_b;
  logic [HALF_W:0]          lo_add;
  logic [HALF_W-1:0]        a_lo;
  logic                     a_cy;
  logic [HI_W-1:0]          a_hs;
  logic [HI_W-1:0]          a_hc;
  logic [HI_W-1:0]          hi_sum;
  logic signed [EXP_W-1:0]  a_exp;
  logic                     a_sign;
  class_t                   a_cls;
  logic [31:0]              rp_result;
  logic                     rp_ovf;
  logic                     rp_unf;
  logic                     rp_inx;

  assign en_b      = !vb || out_ready;
  assign en_a      = !va || en_b;
  assign in_ready  = en_a && !reset;
  assign out_valid = vb;

  assign lo_add = {1'b0, s_vec[HALF_W-1:0]} + {1'b0, c_vec[HALF_W-1:0]};
  assign hi_sum = a_hs + a_hc + HI_W'(a_cy);

  always_ff @(posedge clk) begin
    if (reset) begin
      va     <= 1'b0;
      a_lo   <= '0;
      a_cy   <= 1'b0;
      a_hs   <= '0;
      a_hc   <= '0;
      a_exp  <= '0;
      a_sign <= 1'b0;
      a_cls  <= CLS_NORM;
    end else if (en_a) begin
      va     <= in_valid;
      a_lo   <= lo_add[HALF_W-1:0];
      a_cy   <= lo_add[HALF_W];
      a_hs   <= s_vec[PW-1:HALF_W];
      a_hc   <= c_vec[PW-1:HALF_W];
      a_exp  <= exp_in;
      a_sign <= sign_in;
      a_cls  <= class_t'(class_in);
    end
  end

  fp_round_pack #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_round_pack (
    .p       ({hi_sum, a_lo}),
    .exp_val (a_exp),
    .sign    (a_sign),
    .cls     (a_cls),
    .result  (rp_result),
    .ovf     (rp_ovf),
    .unf     (rp_unf),
    .inx     (rp_inx)
  );

  // Outputs only change when a real entry moves in, so they hold through stalls and bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      vb       <= 1'b0;
      result   <= '0;
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
      flag_inx <= 1'b0;
    end else if (en_b) begin
      vb <= va;
      if (va) begin
        result   <= rp_result;
        flag_ovf <= rp_ovf;
        flag_unf <= rp_unf;
        flag_inx <= rp_inx;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_cpa_round.sv
// Randomized and directed self-checking bench for fp_mul_cpa_round against an arithmetic reference model.
module tb_fp_mul_cpa_round;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [47:0]        s_vec;
  logic [47:0]        c_vec;
  logic signed [9:0]  exp_in;
  logic               sign_in;
  logic [1:0]         class_in;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        result;
  logic               flag_ovf;
  logic               flag_unf;
  logic               flag_inx;

  int errors = 0;
  int checks = 0;

  logic [34:0] sb[$];
  logic        prev_stall = 1'b0;
  logic [34:0] held;

  fp_mul_cpa_round dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_vec     (s_vec),
    .c_vec     (c_vec),
    .exp_in    (exp_in),
    .sign_in   (sign_in),
    .class_in  (class_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inx  (flag_inx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: returns {ovf, unf, inx, result} from plain integer arithmetic on the product
  function automatic logic [34:0] model(input logic [47:0] s, input logic [47:0] c,
                                        input logic [9:0] e_in, input logic sg,
                                        input logic [1:0] cl);
    logic [47:0]     p;
    longint unsigned pv, q, rem, half, frac;
    int              shift, e;
    bit              up;
    bit              inx;
    if (cl == 2'b01) return {3'b000, sg, 31'h0};
    if (cl == 2'b10) return {3'b000, sg, 8'hFF, 23'h0};
    if (cl == 2'b11) return {3'b000, 32'h7FC00000};
    p     = s + c;
    pv    = longint'(p);
    shift = p[47] ? 24 : 23;
    e     = int'($signed(e_in));
    if (p[47]) e = e + 1;
    q     = pv >> shift;
    rem   = pv & ((64'd1 << shift) - 64'd1);
    half  = 64'd1 << (shift - 1);
    frac  = q % (64'd1 << 23);
    up    = (rem > half) || (rem == half && (q % 2) == 1);
    inx   = (rem != 0);
    if (up) begin
      frac = frac + 1;
      if (frac == (64'd1 << 23)) begin
        frac = 0;
        e    = e + 1;
      end
    end
    if (e >= 255) return {3'b101, sg, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b011, sg, 31'h0};
    return {2'b00, inx, sg, 8'(e), 23'(frac)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  // Scoreboard: queue entries on input handshakes, compare on output handshakes, watch stalls
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        checkOutput("stall_hold", {out_valid, flag_ovf, flag_unf, flag_inx, result},
                    {1'b1, held});
      if (out_valid && out_ready) begin
        if (sb.size() == 0)
          checkOutput("unexpected_output", 64'(result), 64'hFFFF_FFFF_FFFF_FFFF);
        else
          checkOutput("scoreboard", {flag_ovf, flag_unf, flag_inx, result}, sb.pop_front());
      end
      if (in_valid && in_ready)
        sb.push_back(model(s_vec, c_vec, exp_in, sign_in, class_in));
      prev_stall = out_valid && !out_ready;
      held       = {flag_ovf, flag_unf, flag_inx, result};
    end
  end

  task automatic applyStimulus(input logic [47:0] s, input logic [47:0] c, input int e,
                               input logic sg, input logic [1:0] cl);
    bit ok;
    bit hs;
    ok = 0;
    @(posedge clk);
    #1;
    s_vec    = s;
    c_vec    = c;
    exp_in   = 10'(e);
    sign_in  = sg;
    class_in = cl;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) ok = 1;
    end
    in_valid = 1'b0;
    if (!ok) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitOutput(output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
    end
    if (!seen) checkOutput("output_timeout", 0, 1);
  endtask

  task automatic runOne(input string name, input logic [47:0] s, input logic [47:0] c,
                        input int e, input logic sg, input logic [1:0] cl,
                        input logic [31:0] exp_res, input logic [2:0] exp_flags);
    int lat;
    out_ready = 1'b1;
    applyStimulus(s, c, e, sg, cl);
    waitOutput(lat);
    checkOutput({name, "_res"}, 64'(result), 64'(exp_res));
    checkOutput({name, "_flags"}, 64'({flag_ovf, flag_unf, flag_inx}), 64'(exp_flags));
  endtask

  task automatic genTxn();
    logic [47:0] p;
    logic [47:0] s;
    int          mode;
    p    = {16'($urandom), 32'($urandom)};
    s    = {16'($urandom), 32'($urandom)};
    mode = $urandom_range(0, 9);
    if (mode < 7) begin
      if (!p[47]) p[46] = 1'b1;
      if (mode == 6) begin
        if (p[47]) begin p[23] = 1'b1; p[22:0] = '0; end
        else       begin p[22] = 1'b1; p[21:0] = '0; end
      end
      s_vec = s;
      c_vec = p - s;
    end else begin
      s_vec = s;
      c_vec = p;
    end
    exp_in   = 10'(int'($urandom_range(0, 300)) - 20);
    sign_in  = 1'($urandom);
    class_in = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
  endtask

  initial begin
    int  lat;
    int  idx;
    int  sent;
    bit  hs;
    logic [47:0] bp_p [4];

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s_vec     = '0;
    c_vec     = '0;
    exp_in    = '0;
    sign_in   = 1'b0;
    class_in  = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 0);
    checkOutput("rst_result", 64'(result), 0);
    checkOutput("rst_flags", 64'({flag_ovf, flag_unf, flag_inx}), 0);
    checkOutput("rst_in_ready", 64'(in_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1.0 x 1.0 with latency check
    out_ready = 1'b1;
    applyStimulus(48'h400000000000, 48'h0, 127, 1'b0, 2'b00);
    waitOutput(lat);
    checkOutput("one_latency", 64'(lat), 2);
    checkOutput("one_res", 64'(result), 64'h3F800000);
    checkOutput("one_flags", 64'({flag_ovf, flag_unf, flag_inx}), 0);

    runOne("cross_carry", 48'h3FFFFFFFFFFF, 48'h000000000001, 127, 1'b0, 2'b00, 32'h3F800000, 3'b000);
    runOne("one_five_sq", 48'h900000000000, 48'h0, 127, 1'b0, 2'b00, 32'h40100000, 3'b000);
    runOne("tie_even",    48'h800000800000, 48'h0, 127, 1'b0, 2'b00, 32'h40000000, 3'b001);
    runOne("tie_odd",     48'h800001800000, 48'h0, 127, 1'b0, 2'b00, 32'h40000002, 3'b001);
    runOne("mant_ovf",    48'hFFFFFF800000, 48'h0, 127, 1'b0, 2'b00, 32'h40800000, 3'b001);
    runOne("exp_ovf",     48'h800000000000, 48'h0, 254, 1'b0, 2'b00, 32'h7F800000, 3'b101);
    runOne("exp_unf",     48'h400000000000, 48'h0, 0,   1'b1, 2'b00, 32'h80000000, 3'b011);
    runOne("nan",         48'h123456789ABC, 48'h0, 127, 1'b1, 2'b11, 32'h7FC00000, 3'b000);
    runOne("inf",         48'h400000000000, 48'h0, 127, 1'b1, 2'b10, 32'hFF800000, 3'b000);
    runOne("zero",        48'h400000000000, 48'h0, 127, 1'b0, 2'b01, 32'h00000000, 3'b000);

    // Backpressure: four back-to-back inputs, output stalled for four cycles
    bp_p[0] = 48'h400000000000;
    bp_p[1] = 48'h900000000000;
    bp_p[2] = 48'h800001800000;
    bp_p[3] = 48'hC00000000000;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
      s_vec    = bp_p[idx];
      c_vec    = '0;
      exp_in   = 10'(120 + idx);
      sign_in  = 1'(idx);
      class_in = 2'b00;
      in_valid = 1'b1;
      if (cyc == 6) out_ready = 1'b1;
      @(negedge clk);
      if (cyc == 4) begin
        checkOutput("bp_accepted", 64'(idx), 2);
        checkOutput("bp_in_ready", 64'(in_ready), 0);
        checkOutput("bp_out_valid", 64'(out_valid), 1);
      end
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("bp_drained", 64'(sb.size()), 0);

    // Reset with both stages full
    out_ready = 1'b0;
    applyStimulus(48'h400000000000, 48'h0, 127, 1'b0, 2'b00);
    applyStimulus(48'h900000000000, 48'h0, 127, 1'b0, 2'b00);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_in_ready", 64'(in_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", 64'(out_valid), 0);
    checkOutput("midrst_result", 64'(result), 0);
    runOne("after_rst", 48'h900000000000, 48'h0, 127, 1'b0, 2'b00, 32'h40100000, 3'b000);

    // Randomized traffic with random backpressure
    sent = 0;
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 5000 && sent < 300; cyc++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        genTxn();
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        in_valid = 1'b0;
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("rand_sent", 64'(sent), 300);
    checkOutput("rand_drained", 64'(sb.size()), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
